// File: rtl/multiplier_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_datapath
// Description : Register datapath for an 8x8 signed add-shift multiplier.
//               Holds the sign-extension bit X, the accumulator A (upper
//               product byte) and the multiplier/lower-product register B.
//               An external controller issues one control per cycle:
//               Clr_Ld, ClrA, Add, Sub or Shift. Simultaneous controls are
//               resolved by fixed priority and flagged on a sticky Err bit.
// Ports       :
//   Clk     in   1  clock, rising edge active
//   Reset   in   1  asynchronous reset, active low
//   S       in   8  switch operand (multiplier on load, multiplicand on run)
//   Clr_Ld  in   1  clear X and A, load B from S (also clears Err if alone)
//   ClrA    in   1  clear X and A, hold B
//   Add     in   1  {X,A} <= {A[7],A} + {S[7],S}
//   Sub     in   1  {X,A} <= {A[7],A} - {S[7],S}
//   Shift   in   1  arithmetic right shift of {X,A,B}, X held
//   Aval    out  8  A register
//   Bval    out  8  B register
//   X       out  1  sign-extension bit of A
//   M       out  1  B[0], next multiplier bit for the controller
//   Err     out  1  sticky illegal-control-combination flag
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_datapath (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] S,
    input  logic       Clr_Ld,
    input  logic       ClrA,
    input  logic       Add,
    input  logic       Sub,
    input  logic       Shift,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       M,
    output logic       Err
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic       r_x;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_err;

    // ------------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------------
    logic [2:0] w_nctl;
    logic       w_multi;
    logic [8:0] w_a_ext;
    logic [8:0] w_s_ext;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic       w_x_nxt;
    logic [7:0] w_a_nxt;
    logic [7:0] w_b_nxt;
    logic       w_err_nxt;

    // Number of controls raised this cycle; two or more is illegal.
    assign w_nctl  = {2'b00, Clr_Ld} + {2'b00, ClrA} + {2'b00, Add}
                   + {2'b00, Sub}    + {2'b00, Shift};
    assign w_multi = (w_nctl > 3'd1);

    // Both operands are sign-extended to 9 bits so X carries the true sign
    // of the result; the 9-bit result wraps with no overflow detection.
    assign w_a_ext = {r_a[7], r_a};
    assign w_s_ext = {S[7], S};
    assign w_sum   = w_a_ext + w_s_ext;
    assign w_diff  = w_a_ext + ~w_s_ext + 9'd1;

    always_comb begin
        w_x_nxt = r_x;
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        // Fixed priority: only the highest-ranked control takes effect.
        if (Clr_Ld) begin
            w_x_nxt = 1'b0;
            w_a_nxt = 8'h00;
            w_b_nxt = S;
        end else if (ClrA) begin
            w_x_nxt = 1'b0;
            w_a_nxt = 8'h00;
        end else if (Sub) begin
            w_x_nxt = w_diff[8];
            w_a_nxt = w_diff[7:0];
        end else if (Add) begin
            w_x_nxt = w_sum[8];
            w_a_nxt = w_sum[7:0];
        end else if (Shift) begin
            w_a_nxt = {r_x, r_a[7:1]};
            w_b_nxt = {r_a[0], r_b[7:1]};
        end
    end

    // Err is sticky: a collision always sets it, and only a lone Clr_Ld
    // (which cannot also be a collision) clears it.
    always_comb begin
        w_err_nxt = r_err;
        if (w_multi) begin
            w_err_nxt = 1'b1;
        end else if (Clr_Ld) begin
            w_err_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_x   <= 1'b0;
            r_a   <= 8'h00;
            r_b   <= 8'h00;
            r_err <= 1'b0;
        end else begin
            r_x   <= w_x_nxt;
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_err <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;
    assign M    = r_b[0];
    assign Err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_datapath
// Description : Scoreboard bench for multiplier_datapath. The stimulus
//               process pushes the hand-computed expected register state
//               after each checked operation; an independent monitor pops
//               and compares entries on the falling clock edge (or at once
//               when signalled, for asynchronous-reset checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_datapath;

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_SHIFT = 5'b00001;
    localparam logic [4:0] C_ADD   = 5'b00010;
    localparam logic [4:0] C_SUB   = 5'b00100;
    localparam logic [4:0] C_CLRA  = 5'b01000;
    localparam logic [4:0] C_CLRLD = 5'b10000;

    logic       Clk;
    logic       Reset;
    logic [7:0] S;
    logic       Clr_Ld, ClrA, Add, Sub, Shift;
    logic [7:0] Aval, Bval;
    logic       X, M, Err;

    typedef struct {
        string      name;
        logic       x;
        logic [7:0] a;
        logic [7:0] b;
        logic       err;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event ev_chk;

    multiplier_datapath dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .S      (S),
        .Clr_Ld (Clr_Ld),
        .ClrA   (ClrA),
        .Add    (Add),
        .Sub    (Sub),
        .Shift  (Shift),
        .Aval   (Aval),
        .Bval   (Bval),
        .X      (X),
        .M      (M),
        .Err    (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------------
    // Monitor: compares every queued expectation against the live outputs.
    // M is expected to mirror the expected B[0].
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk or ev_chk);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_cmp++;
                if (X !== e.x || Aval !== e.a || Bval !== e.b ||
                    M !== e.b[0] || Err !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: got X=%b A=%h B=%h M=%b Err=%b, want X=%b A=%h B=%h M=%b Err=%b",
                             e.name, X, Aval, Bval, M, Err,
                             e.x, e.a, e.b, e.b[0], e.err);
                end
            end
        end
    end

    task automatic push(input string name, input logic ex, input logic [7:0] ea,
                        input logic [7:0] eb, input logic eerr);
        exp_t e;
        e.name = name;
        e.x    = ex;
        e.a    = ea;
        e.b    = eb;
        e.err  = eerr;
        q_exp.push_back(e);
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [7:0] s);
        {Clr_Ld, ClrA, Sub, Add, Shift} = ctl;
        S = s;
    endtask

    // One clock of a control; optionally queues the expected post-edge state.
    task automatic step(input logic [4:0] ctl, input logic [7:0] s, input bit chk,
                        input string name, input logic ex, input logic [7:0] ea,
                        input logic [7:0] eb, input logic eerr);
        @(negedge Clk);
        drive(ctl, s);
        @(posedge Clk);
        #1;
        drive(C_NONE, s);
        if (chk) push(name, ex, ea, eb, eerr);
    endtask

    // Add/Sub-then-Shift sequence; the multiplier bit is known from the
    // loaded operand, so the bench does not consult M to steer the run.
    task automatic run_mult(input logic [7:0] mplr, input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (mplr[i])
                step((i == 7) ? C_SUB : C_ADD, s, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
            step(C_SHIFT, s, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        Reset = 1'b0;
        drive(C_CLRLD, 8'hAA);

        // Controls ignored while in reset
        repeat (2) @(posedge Clk);
        #1;
        push("reset_state", 1'b0, 8'h00, 8'h00, 1'b0);
        -> ev_chk;
        @(negedge Clk);
        drive(C_NONE, 8'h00);
        Reset = 1'b1;

        // Load / clear
        step(C_CLRLD, 8'h5A, 1'b1, "clr_ld_5a", 1'b0, 8'h00, 8'h5A, 1'b0);
        step(C_CLRA,  8'h33, 1'b1, "clra_hold_b", 1'b0, 8'h00, 8'h5A, 1'b0);
        step(C_NONE,  8'hFF, 1'b1, "idle_hold", 1'b0, 8'h00, 8'h5A, 1'b0);

        // 7 x -3 = -21
        step(C_CLRLD, 8'h07, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_CLRA,  8'hFD, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_ADD,   8'hFD, 1'b1, "mul_first_add", 1'b1, 8'hFD, 8'h07, 1'b0);
        step(C_SHIFT, 8'hFD, 1'b1, "mul_first_shift", 1'b1, 8'hFE, 8'h83, 1'b0);
        step(C_CLRA,  8'hFD, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_CLRLD, 8'h07, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_CLRA,  8'hFD, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        run_mult(8'h07, 8'hFD);
        step(C_NONE, 8'hFD, 1'b1, "mul_7_x_m3", 1'b1, 8'hFF, 8'hEB, 1'b0);

        // -128 x 2 = -256, Sub on the sign bit
        step(C_CLRLD, 8'h80, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_CLRA,  8'h02, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++)
            step(C_SHIFT, 8'h02, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_SUB,   8'h02, 1'b1, "mul_sub_step", 1'b1, 8'hFE, 8'h01, 1'b0);
        step(C_SHIFT, 8'h02, 1'b1, "mul_m128_x_2", 1'b1, 8'hFF, 8'h00, 1'b0);

        // Arithmetic boundaries
        step(C_CLRLD, 8'h5A, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_ADD,   8'h7F, 1'b1, "add_7f", 1'b0, 8'h7F, 8'h5A, 1'b0);
        step(C_ADD,   8'h01, 1'b1, "add_wrap_80", 1'b0, 8'h80, 8'h5A, 1'b0);
        step(C_CLRA,  8'h00, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_SUB,   8'h80, 1'b1, "sub_neg128", 1'b0, 8'h80, 8'h5A, 1'b0);
        step(C_CLRA,  8'h00, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);

        // Priority and sticky Err
        step(C_ADD | C_SHIFT, 8'h03, 1'b1, "prio_add_shift", 1'b0, 8'h03, 8'h5A, 1'b1);
        step(C_SHIFT, 8'h03, 1'b1, "err_sticky_shift", 1'b0, 8'h01, 8'hAD, 1'b1);
        step(C_ADD,   8'h03, 1'b1, "err_sticky_add", 1'b0, 8'h04, 8'hAD, 1'b1);
        step(C_CLRA,  8'h03, 1'b1, "err_sticky_clra", 1'b0, 8'h00, 8'hAD, 1'b1);
        step(C_CLRLD, 8'h11, 1'b1, "err_clear", 1'b0, 8'h00, 8'h11, 1'b0);
        step(C_CLRLD | C_SUB, 8'h22, 1'b1, "prio_clrld_sub", 1'b0, 8'h00, 8'h22, 1'b1);
        step(C_SUB | C_ADD, 8'h01, 1'b1, "prio_sub_add", 1'b1, 8'hFF, 8'h22, 1'b1);
        step(C_CLRLD, 8'h33, 1'b1, "err_clear2", 1'b0, 8'h00, 8'h33, 1'b0);

        // Reset in the middle of a Shift cycle
        step(C_CLRLD, 8'h81, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_CLRA,  8'h05, 1'b0, "", 1'b0, 8'h00, 8'h00, 1'b0);
        step(C_ADD | C_SHIFT, 8'h05, 1'b1, "pre_rst_add", 1'b0, 8'h05, 8'h81, 1'b1);
        @(negedge Clk);
        drive(C_SHIFT, 8'h05);
        @(posedge Clk);
        #1;
        push("pre_rst_shift", 1'b0, 8'h02, 8'hC0, 1'b1);
        -> ev_chk;
        #1;
        Reset = 1'b0;
        #1;
        push("rst_async", 1'b0, 8'h00, 8'h00, 1'b0);
        -> ev_chk;
        drive(C_NONE, 8'h05);
        Reset = 1'b1;
        step(C_NONE, 8'h05, 1'b1, "rst_release_hold", 1'b0, 8'h00, 8'h00, 1'b0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && q_exp.size() > 0; i++) @(negedge Clk);
        #1;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplier_datapath.md
MULTIPLIER_DATAPATH -- requirements
Module: multiplier_datapath

Interface
REQ-001 The module SHALL have these ports, one per line (name, direction, width, meaning), clock and reset first:
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 S  input  8  switch operand, two's complement; multiplier on load, multiplicand during run.
REQ-005 Clr_Ld  input  1  clear X and A, load B from S.
REQ-006 ClrA  input  1  clear X and A only; B is held.
REQ-007 Add  input  1  A <= A + S, sign-extended.
REQ-008 Sub  input  1  A <= A - S, sign-extended.
REQ-009 Shift  input  1  arithmetic right shift of {X,A,B}.
REQ-010 Aval  output  8  A register (upper product byte).
REQ-011 Bval  output  8  B register (lower product byte / remaining multiplier).
REQ-012 X  output  1  sign-extension bit of A.
REQ-013 M  output  1  B[0], fed back to the controller.
REQ-014 Err  output  1  sticky flag for an illegal control combination.

Function
REQ-015 State SHALL be X (1 bit), A (8 bits), B (8 bits) and Err (1 bit); Aval = A, Bval = B, M = B[0], all combinational from the registers.
REQ-016 Exactly one control input is legal per cycle; if several are asserted, priority SHALL be Clr_Ld > ClrA > Sub > Add > Shift, and only the winner acts.
REQ-017 Clr_Ld: next cycle X=0, A=0x00, B=S.
REQ-018 ClrA: next cycle X=0, A=0x00, B unchanged.
REQ-019 Add: 9-bit sum = {A[7],A} + {S[7],S}; A <= sum[7:0], X <= sum[8]; B unchanged.
REQ-020 Sub: 9-bit diff = {A[7],A} + ~{S[7],S} + 1; A <= diff[7:0], X <= diff[8]; B unchanged.
REQ-021 Shift: X unchanged, A <= {X, A[7:1]}, B <= {A[0], B[7:1]}.
REQ-022 Add and Sub SHALL wrap modulo 2^9 with no saturation or overflow flag; the 0x7F + 0x01 case yields A=0x80, X=0.
REQ-023 No control asserted: all registers hold.
REQ-024 Err SHALL set on any rising edge where two or more of Clr_Ld, ClrA, Add, Sub, Shift are high.
REQ-025 Err is sticky; it clears only on Clr_Ld (when Clr_Ld alone is asserted) or on Reset.
REQ-026 Each operation SHALL have single-cycle latency: the result is visible on the outputs after the edge where the control was sampled.
REQ-027 Using the sequence of 7 x (Add if M, then Shift), then (Sub if M, then Shift), after ClrA the module SHALL produce the signed 16-bit product {A,B}, with X equal to the product sign.

Reset
REQ-028 While Reset=0, asynchronously: X=0, A=0x00, B=0x00, Err=0, hence M=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no partial update.
REQ-030 Control inputs SHALL be ignored while Reset=0; the first active edge after release acts normally.

Verification
REQ-031 Load/clear scenario:
- Reset pulse; Clr_Ld with S=0x5A -> A=0x00, B=0x5A, X=0, M=0.
- Then ClrA -> A=0x00, B=0x5A.
REQ-032 Positive x negative: Clr_Ld S=0x07; ClrA with S=0xFD held; run the full 8-bit add/shift/sub sequence -> {A,B}=0xFFEB (-21), X=1.
REQ-033 Negative multiplier, Sub path: Clr_Ld S=0x80; ClrA with S=0x02; full sequence -> intermediate Sub gives A=0xFE, X=1; final {A,B}=0xFF00 (-256), X=1.
REQ-034 Arithmetic boundaries:
- A=0x7F, Add with S=0x01 -> A=0x80, X=0.
- A=0x00, Sub with S=0x80 -> A=0x80, X=0 (9-bit +128).
REQ-035 Priority and Err: Add and Shift together with A=0x00, S=0x03 -> A=0x03, B unchanged, Err=1.
- Err stays 1 through later single controls.
- Clr_Ld alone -> Err=0.
REQ-036 Reset mid-run: pull Reset low for 1 ns between edges during a Shift cycle -> X, A, B and Err read 0 immediately; the next edge after release with no controls holds zeros.
